// File: rtl/bp_pkg.sv
// Shared helpers for the branch predictor: table sizing, saturating counter
// arithmetic and the table index hash.
package bp_pkg;

  function automatic int unsigned num_entries(input int unsigned idx_w);
    return 32'd1 << idx_w;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned cnt, input int unsigned cnt_w);
    int unsigned max_cnt;
    max_cnt = (32'd1 << cnt_w) - 32'd1;
    return (cnt >= max_cnt) ? max_cnt : cnt + 32'd1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned cnt);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  function automatic int unsigned sat_step(input int unsigned cnt, input int unsigned cnt_w,
                                           input bit up);
    return up ? sat_inc(cnt, cnt_w) : sat_dec(cnt);
  endfunction

  // History is zero-extended into the index; bimodal mode ignores it entirely.
  function automatic int unsigned hash_idx(input int unsigned pc_idx, input int unsigned ghr,
                                           input bit gshare);
    return gshare ? (pc_idx ^ ghr) : pc_idx;
  endfunction

endpackage

// File: rtl/sat_counter_array.sv
// Array of saturating counters: one combinational read port, one saturating
// write port, asynchronous clear of every entry to INIT_CNT.
module sat_counter_array
  import bp_pkg::*;
#(
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 2,
  parameter int INIT_CNT = 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CNT_W-1:0] rd_cnt,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_up,
  output logic [CNT_W-1:0] wr_cnt_next
);

  localparam int unsigned DEPTH = num_entries(IDX_W);

  logic [CNT_W-1:0] cnt_reg [DEPTH];

  assign rd_cnt = cnt_reg[rd_idx];

  // Value the written entry will take; also exported so the top can bypass it.
  assign wr_cnt_next = CNT_W'(sat_step(32'(cnt_reg[wr_idx]), CNT_W, wr_up));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        cnt_reg[i] <= CNT_W'(INIT_CNT);
      end
    end else if (wr_en) begin
      cnt_reg[wr_idx] <= wr_cnt_next;
    end
  end

endmodule

// File: rtl/branch_history_table_param.sv
// Parametrised branch history table with optional gshare indexing, global
// history speculation/restore and same-cycle update-to-lookup bypass.
module branch_history_table_param
  import bp_pkg::*;
#(
  parameter int ADDR_W   = 7,
  parameter int IDX_W    = 5,
  parameter int CNT_W    = 2,
  parameter int GHR_W    = 5,
  parameter int GSHARE   = 0,
  parameter int INIT_CNT = 1
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              rd_valid,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  input  logic              upd_mispred,
  input  logic [GHR_W-1:0]  upd_ghr,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [GHR_W-1:0]  pred_ghr,
  output logic [CNT_W-1:0]  pred_cnt
);

  logic [IDX_W-1:0] rd_pc_idx;
  logic [IDX_W-1:0] upd_pc_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] upd_idx;
  logic [CNT_W-1:0] rd_cnt;
  logic [CNT_W-1:0] upd_cnt_next;
  logic [CNT_W-1:0] lookup_cnt;
  logic             upd_fire;
  logic             bypass;

  logic [GHR_W-1:0] ghr_reg, ghr_next;
  logic             pred_valid_reg, pred_valid_next;
  logic             pred_taken_reg, pred_taken_next;
  logic [GHR_W-1:0] pred_ghr_reg, pred_ghr_next;
  logic [CNT_W-1:0] pred_cnt_reg, pred_cnt_next;

  // Only the word index bits select an entry; the rest of the PC is ignored.
  logic addr_unused;
  assign addr_unused = ^{rd_addr, upd_addr};

  assign rd_pc_idx  = rd_addr[IDX_W+1:2];
  assign upd_pc_idx = upd_addr[IDX_W+1:2];

  // The update side hashes with the snapshot so it retrains the predicting entry.
  assign rd_idx  = IDX_W'(hash_idx(32'(rd_pc_idx), 32'(ghr_reg), GSHARE != 0));
  assign upd_idx = IDX_W'(hash_idx(32'(upd_pc_idx), 32'(upd_ghr), GSHARE != 0));

  assign upd_fire = en & upd_valid;

  sat_counter_array #(
    .IDX_W    (IDX_W),
    .CNT_W    (CNT_W),
    .INIT_CNT (INIT_CNT)
  ) u_counters (
    .clk         (clk),
    .arst        (arst),
    .rd_idx      (rd_idx),
    .rd_cnt      (rd_cnt),
    .wr_en       (upd_fire),
    .wr_idx      (upd_idx),
    .wr_up       (upd_taken),
    .wr_cnt_next (upd_cnt_next)
  );

  assign bypass     = upd_fire && (rd_idx == upd_idx);
  assign lookup_cnt = bypass ? upd_cnt_next : rd_cnt;

  always_comb begin
    pred_valid_next = 1'b0;
    pred_taken_next = pred_taken_reg;
    pred_ghr_next   = pred_ghr_reg;
    pred_cnt_next   = pred_cnt_reg;
    ghr_next        = ghr_reg;

    if (en && rd_valid) begin
      pred_valid_next = 1'b1;
      pred_taken_next = lookup_cnt[CNT_W-1];
      pred_ghr_next   = ghr_reg;
      pred_cnt_next   = lookup_cnt;
    end

    // A mispredict restore wins over this cycle's speculative shift.
    if (en) begin
      if (upd_valid && upd_mispred) begin
        ghr_next = GHR_W'({upd_ghr, upd_taken});
      end else if (rd_valid) begin
        ghr_next = GHR_W'({ghr_reg, lookup_cnt[CNT_W-1]});
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ghr_reg        <= '0;
      pred_valid_reg <= 1'b0;
      pred_taken_reg <= 1'b0;
      pred_ghr_reg   <= '0;
      pred_cnt_reg   <= '0;
    end else begin
      ghr_reg        <= ghr_next;
      pred_valid_reg <= pred_valid_next;
      pred_taken_reg <= pred_taken_next;
      pred_ghr_reg   <= pred_ghr_next;
      pred_cnt_reg   <= pred_cnt_next;
    end
  end

  assign pred_valid = pred_valid_reg;
  assign pred_taken = pred_taken_reg;
  assign pred_ghr   = pred_ghr_reg;
  assign pred_cnt   = pred_cnt_reg;

endmodule

// File: doc/branch_history_table_param.md
Name: branch_history_table_param

Overview:
- Parametrised successor to the fixed 32-entry, 2-bit bimodal branch history table in the fetch stage.
- Provides depth, counter width and index-hashing mode as parameters.
- Adds a global history register (GHR) with gshare hashing, mispredict history restore, and a same-cycle update-to-read bypass.
- Prediction is registered, one cycle after the fetch-side lookup. The update port is driven by the execute stage on branch/jump resolution.

Parameters:
- ADDR_W, 7: width of the byte PC slice presented on both address ports.
- IDX_W, 5: table index width; the table holds 2**IDX_W entries. Constraint: IDX_W+2 <= ADDR_W.
- CNT_W, 2: saturating counter width; the prediction is the counter MSB.
- GHR_W, 5: global history length. Constraint: GHR_W <= IDX_W.
- GSHARE, 0: 0 selects bimodal indexing; 1 selects gshare indexing (PC index XOR history).
- INIT_CNT, 1: counter value after reset (weakly not-taken for CNT_W=2). Constraint: INIT_CNT < 2**CNT_W.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- arst  in  1  asynchronous reset, active-high
- en  in  1  global enable; low freezes all state and deasserts pred_valid
- rd_valid  in  1  lookup request this cycle
- rd_addr  in  ADDR_W  PC of the instruction being fetched
- upd_valid  in  1  resolved branch/jump update this cycle
- upd_addr  in  ADDR_W  PC of the resolved instruction
- upd_taken  in  1  resolved direction; jumps are driven as 1
- upd_mispred  in  1  resolution disagreed with the prediction; qualified by upd_valid
- upd_ghr  in  GHR_W  GHR snapshot returned with the original prediction
- pred_valid  out  1  pred_taken/pred_ghr valid, one cycle after rd_valid
- pred_taken  out  1  predicted direction
- pred_ghr  out  GHR_W  GHR value used to form the index; pipelined to execute
- pred_cnt  out  CNT_W  raw counter value, for debug and performance counters

Behaviour:
- Reset (arst=1, immediate):
  - every counter is set to INIT_CNT;
  - GHR is set to 0;
  - pred_valid, pred_taken, pred_ghr and pred_cnt are set to 0.
  - Reset during an in-flight lookup discards that lookup; pred_valid stays 0 on the first edge after release.
- Indexing: pc_idx = addr[IDX_W+1:2] (word-aligned PCs).
  - GSHARE=0: idx = pc_idx.
  - GSHARE=1: idx = pc_idx XOR zero-extended history.
    - Read side uses the current GHR.
    - Update side uses upd_ghr, so it retrains the same entry that made the prediction.
- Lookup, latency 1: if en & rd_valid at edge N, then at edge N the block registers:
  - pred_valid=1;
  - pred_taken = MSB of the counter;
  - pred_cnt = the counter;
  - pred_ghr = the GHR before this cycle's shift.
  - Otherwise pred_valid=0 and the other prediction outputs hold their last values.
- Counter update (en & upd_valid):
  - upd_taken=1: counter+1, saturating at 2**CNT_W-1.
  - upd_taken=0: counter-1, saturating at 0.
  - Only the indexed entry changes.
- Bypass: if a lookup and an update hit the same index in the same cycle, the prediction returns the post-update counter value.
- GHR update (en=1), priority high to low:
  1. upd_valid & upd_mispred: GHR = {upd_ghr[GHR_W-2:0], upd_taken}. This restore squashes any same-cycle speculative shift.
  2. rd_valid: GHR = {GHR[GHR_W-2:0], predicted direction}. The predicted direction is the bypassed value, so it is consistent with pred_taken.
  3. Otherwise the GHR holds.
- GSHARE=0: the GHR is still maintained and exported for observability, but is not used for indexing.
- en=0: counters, GHR and the prediction registers hold. pred_valid is driven 0 on the next edge.
- Out-of-range upper address bits are ignored; no error condition exists.

Decomposition:
- Shared package bp_pkg holds:
  - localparam function for entry count (2**IDX_W);
  - counter saturating increment/decrement functions;
  - index-hash function.
- One natural sub-module: sat_counter_array.
  - Contains the 2**IDX_W x CNT_W register array, one combinational read port, one saturating write port, and arst clear to INIT_CNT.
  - The top level owns hashing, bypass, the GHR and the output registers.

Test Plan:
- Reset then idle: assert arst for 2 cycles, release, issue rd_valid at PC 0x10 -> pred_valid=1, pred_taken=0, pred_cnt=1, pred_ghr=0.
- Saturation up: with GSHARE=0, three taken updates at PC 0x08 -> counter steps 1,2,3,3. A lookup of 0x08 returns pred_cnt=3, pred_taken=1. A fourth taken update leaves the counter at 3.
- Saturation down: four not-taken updates from counter 3 at PC 0x0C -> 2,1,0,0. A lookup returns pred_cnt=0, pred_taken=0.
- Bypass: counter at PC 0x04 =1; same-cycle update(taken) and lookup of 0x04 -> pred_cnt=2, pred_taken=1 next cycle.
- GHR speculation and restore (GSHARE=1, GHR_W=5):
  - Lookups predicted T,T,N give GHR=00110.
  - Then, in the same cycle, upd_mispred=1 with upd_ghr=00001 and upd_taken=0, together with rd_valid -> GHR=00010; the speculative shift is dropped.
- Reset mid-operation: assert arst in the same cycle as rd_valid with 5 entries trained -> after release, all entries read INIT_CNT, GHR=0, no pred_valid pulse for the discarded lookup.
